// File: rtl/tt_chk_pkg.sv
// Shared types and helpers for the truth-table checker.
// State encoding, gate mode constants and the ideal gate function.
// Imported by the checker top level.
package tt_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic MODE_NAND = 1'b0;
  localparam logic MODE_NOR  = 1'b1;

  // Ideal output of an n-input NAND/NOR for input vector vec (n <= 4).
  function automatic logic exp_out(input logic mode, input logic [3:0] vec,
                                   input int unsigned n);
    logic [3:0] mask;
    mask = 4'((1 << n) - 1);
    if (mode == MODE_NOR)
      return (vec & mask) == 4'd0;
    else
      return (vec & mask) != mask;
  endfunction

endpackage

// File: rtl/gate_n_sw.sv
// Switch-level N-input CMOS gate built from MOS primitives.
// Combinational; output reflects inputs after network propagation.
// No flow control; mode selects the NAND or NOR network.
module gate_n_sw #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic         mode,
  output wire          y
);

  supply1 vdd;
  supply0 gnd;

  wire y_nand;
  wire y_nor;
  // Internal nodes of the series stacks; node N ties to the rail.
  wire [N:1] pd_node;
  wire [N:1] pu_node;

  assign pd_node[N] = gnd;
  assign pu_node[N] = vdd;

  for (genvar i = 0; i < N; i++) begin : g_net
    // NAND pull-up and NOR pull-down: one parallel device per input
    pmos p_par (y_nand, vdd, a[i]);
    nmos n_par (y_nor,  gnd, a[i]);
    if (i == 0) begin : g_top
      nmos n_ser (y_nand, pd_node[1], a[0]);
      pmos p_ser (y_nor,  pu_node[1], a[0]);
    end else begin : g_mid
      nmos n_ser (pd_node[i], pd_node[i+1], a[i]);
      pmos p_ser (pu_node[i], pu_node[i+1], a[i]);
    end
  end

  assign y = mode ? y_nor : y_nand;

endmodule

// File: rtl/nand_tt_checker.sv
// Sweeps all input vectors through a switch-level NAND/NOR and checks the truth table.
// Latency: done 1 + 2**N_IN*(SETTLE_CYC+1) cycles after the accepting edge.
// No backpressure; start is only accepted in IDLE and ignored otherwise.
module nand_tt_checker
  import tt_chk_pkg::*;
#(
  parameter int N_IN       = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic               inj_en,
  input  logic [N_IN-1:0]    inj_idx,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2**N_IN-1:0] tt,
  output logic [N_IN:0]      fail_cnt,
  output logic [N_IN-1:0]    fail_idx,
  output logic [N_IN-1:0]    gate_in,
  output logic               gate_y
);

  localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [N_IN-1:0] VEC_LAST    = N_IN'(2**N_IN - 1);
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYC - 1);

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [CW-1:0]   settle_cnt;
  logic            mode_q;
  logic            inj_en_q;
  logic [N_IN-1:0] inj_idx_q;
  wire             sw_y;
  logic            miss;
  logic [N_IN:0]   fail_cnt_nxt;

  gate_n_sw #(.N(N_IN)) u_gate (
    .a    (gate_in),
    .mode (mode_q),
    .y    (sw_y)
  );

  // Fault injection flips the observed output for the selected vector only.
  assign gate_y = sw_y ^ (inj_en_q & (vec == inj_idx_q));

  // Compare sampled output to the ideal function; X/Z never equals a 0/1 expectation.
  always_comb begin
    miss         = (gate_y !== exp_out(mode_q, 4'(vec), N_IN));
    fail_cnt_nxt = fail_cnt + (N_IN+1)'(miss);
  end

  // Sweep sequencer with registered results and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      mode_q     <= MODE_NAND;
      inj_en_q   <= 1'b0;
      inj_idx_q  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      tt         <= '0;
      fail_cnt   <= '0;
      fail_idx   <= '0;
      gate_in    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            inj_en_q   <= inj_en;
            inj_idx_q  <= inj_idx;
            tt         <= '0;
            fail_cnt   <= '0;
            fail_idx   <= '0;
            pass       <= 1'b0;
            vec        <= '0;
            gate_in    <= '0;
            settle_cnt <= '0;
            busy       <= 1'b1;
            state      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          settle_cnt <= settle_cnt + CW'(1);
          if (settle_cnt == SETTLE_LAST)
            state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          tt[vec] <= gate_y;
          if (miss) begin
            fail_cnt <= fail_cnt_nxt;
            if (fail_cnt == '0)
              fail_idx <= vec;
          end
          if (vec == VEC_LAST) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (fail_cnt_nxt == '0);
            state <= ST_DONE;
          end else begin
            vec        <= vec + N_IN'(1);
            gate_in    <= vec + N_IN'(1);
            settle_cnt <= '0;
            state      <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nand_tt_checker.md
Name: nand_tt_checker

Overview:
- Self-checking truth-table sequencer for an N-input switch-level CMOS gate. Supports NAND and NOR.
- On `start`, it drives every input combination into an internal switch-level gate and waits a programmable settle time before sampling the output.
- It captures the full truth table, compares it against the ideal function, and reports pass/fail, the mismatch count and the first failing vector.
- It is the parametrised, clocked successor to the two-input switch-level NAND cell, and is used as an on-chip gate characterisation block.

Parameters:
- N_IN, 2, number of gate inputs; legal range 1..4.
- SETTLE_CYC, 2, cycles each vector is held before sampling; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request to run a sweep; sampled only in IDLE.
- mode  in  1  0 = NAND, 1 = NOR; latched on accepted start.
- inj_en  in  1  fault injection enable; latched on accepted start.
- inj_idx  in  N_IN  vector whose sampled output is inverted when inj_en is set; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start through the last SAMPLE cycle.
- done  out  1  one-cycle pulse; results are valid from this cycle.
- pass  out  1  1 when fail_cnt == 0; valid from done and held until the next start.
- tt  out  2**N_IN  captured truth table; bit v is the output for input vector v.
- fail_cnt  out  N_IN+1  number of mismatching vectors.
- fail_idx  out  N_IN  first mismatching vector; 0 if none.
- gate_in  out  N_IN  vector currently driven into the gate; for observation.
- gate_y  out  1  raw gate output, after injection.

Behaviour:
- Reset (rst_n low at a rising edge), valid from the next cycle:
  - state = IDLE; vec and settle_cnt = 0.
  - busy, done, pass, tt, fail_cnt, fail_idx and gate_in all 0.
  - Reset mid-sweep aborts the sweep; no done is generated.
- States: IDLE -> DRIVE -> SAMPLE -> (DRIVE | DONE) -> IDLE.
- IDLE:
  - On start = 1: latch mode/inj_en/inj_idx, clear tt/fail_cnt/fail_idx/pass, set vec = 0 and settle_cnt = 0, go to DRIVE.
  - Otherwise hold all results.
- DRIVE:
  - gate_in = vec; settle_cnt increments each cycle.
  - When settle_cnt == SETTLE_CYC-1, go to SAMPLE.
- SAMPLE:
  - y_s = gate_y (injection is already applied to gate_y when vec == inj_idx and inj_en = 1).
  - tt[vec] <= y_s.
  - Expected value: NAND gives ~&vec; NOR gives ~|vec.
  - Mismatch, or y_s not 0/1 (X/Z from a floating switch network), counts as a failure: fail_cnt increments, and fail_idx <= vec if fail_cnt was 0.
  - If vec == 2**N_IN-1, go to DONE; else vec++, settle_cnt = 0, go to DRIVE.
- DONE:
  - done = 1 for exactly one cycle; pass = (fail_cnt == 0); busy = 0.
  - Go to IDLE.
- Latency: an accepted start at edge k gives done high in cycle k + 1 + 2**N_IN * (SETTLE_CYC + 1).
  - Example: N_IN = 2, SETTLE_CYC = 2 gives 13 cycles.
- Boundary conditions:
  - start while busy is ignored; mode/inj changes during a sweep are ignored.
  - start asserted in the DONE cycle is ignored. Back-to-back runs need start in IDLE.
  - fail_cnt cannot overflow, because the maximum count 2**N_IN fits in N_IN+1 bits.

Decomposition:
- Package tt_chk_pkg holds:
  - state encoding: IDLE = 0, DRIVE = 1, SAMPLE = 2, DONE = 3;
  - constants MODE_NAND = 0, MODE_NOR = 1;
  - function exp_out(mode, vec).
- Sub-module gate_n_sw (parameter N). It is built with supply1/supply0 and pmos/nmos primitives inside a generate loop:
  - NAND network: parallel pull-up, series pull-down.
  - NOR network: series pull-up, parallel pull-down.
  - A continuous-assignment mux selects the network by mode.
- Fault injection is an XOR after gate_n_sw, in the top level.

Test Plan:
- NAND, N_IN = 2, SETTLE_CYC = 2, inj_en = 0, one start pulse -> done 13 cycles later; tt = 4'b0111, pass = 1, fail_cnt = 0, fail_idx = 0.
- NOR, N_IN = 2 -> tt = 4'b0001, pass = 1.
- NAND with inj_en = 1, inj_idx = 2 -> tt = 4'b0011, pass = 0, fail_cnt = 1, fail_idx = 2.
- N_IN = 3, SETTLE_CYC = 1, NAND -> done 17 cycles after start; tt = 8'h7F, pass = 1.
- start re-pulsed at cycle 5 of a sweep, plus a mode toggle during the sweep -> ignored; single done; results match the originally latched mode.
- rst_n low for one cycle in the middle of the sweep -> next cycle busy = 0, tt = 0, gate_in = 0, no done.
  - A following start then completes normally with pass = 1.
